// File: rtl/mem_bus2_arbiter_pkg.sv
// Shared definitions for the bus-2 line-transfer arbiter.
//   - Geometry of the cache line and of bus 2 (bytes), plus the memory's
//     response latency in cycles.
//   - Bus-2 command encodings carried on mem_cmd.
//   - Arbiter FSM state type and a port-to-one-hot helper.
package mem_bus2_arbiter_pkg;

  localparam int BITS_IN_BYTE      = 8;
  localparam int cache_line_size   = 32;  // bytes per cache line
  localparam int data2_bus_size    = 4;   // bytes per bus-2 data beat
  localparam int addr2_bus_size    = 4;   // bytes of bus-2 address
  localparam int mem_feedback_time = 4;   // cycles from command to C2_RESPONSE

  // NOP must be the all-zero code: an undriven bus then never decodes as a
  // response.
  localparam logic [1:0] C2_NOP        = 2'b00;
  localparam logic [1:0] C2_READ_LINE  = 2'b01;
  localparam logic [1:0] C2_WRITE_LINE = 2'b10;
  localparam logic [1:0] C2_RESPONSE   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    WR_BURST,
    WAIT_RSP,
    RD_BURST
  } state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus2_arbiter_rr.sv
// Two-way round-robin grant.
//   clk, reset : clock and asynchronous active-high reset
//   req        : request vector (already qualified by the caller)
//   advance    : the grant offered this cycle is being taken
//   grant      : at most one bit set; a lone request is always granted
// On a tie the port granted last loses; after reset port 0 wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_q;  // 1: port 1 wins a tie

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
  end

  // NOTE: registered state is always assigned with <= so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        prio_q <= 1'b0;
    else if (advance) prio_q <= grant[0];
  end

endmodule

// File: rtl/mem_bus2_arbiter.sv
// Arbitrates two line-transfer requesters onto the shared bus 2.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : per-port request handshake (ready is combinational)
//   req_write/req_addr/req_wdata : per-port line transfer description
//   rsp_valid           : one-cycle completion pulse to the owning port
//   rsp_err             : completion was a response timeout
//   rsp_rdata           : last successfully read line
//   mem_addr            : bus-2 address
//   mem_cmd/mem_data    : bidirectional bus 2; this master drives them in
//                         IDLE, RD_CMD and WR_BURST only, otherwise high-Z
module mem_bus2_arbiter
  import mem_bus2_arbiter_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 1023,
  localparam int LW = cache_line_size * BITS_IN_BYTE,
  localparam int AW = addr2_bus_size * BITS_IN_BYTE,
  localparam int DW = data2_bus_size * BITS_IN_BYTE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [1:0][AW-1:0]  req_addr,
  input  logic [1:0][LW-1:0]  req_wdata,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [LW-1:0]       rsp_rdata,
  output logic [AW-1:0]       mem_addr,
  inout  wire  [DW-1:0]       mem_data,
  inout  wire  [1:0]          mem_cmd
);

  localparam int BEATS = cache_line_size / data2_bus_size;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);

  state_t state_q, state_d;

  logic          own_bus;
  logic [1:0]    cmd_o;
  logic [DW-1:0] data_o;

  logic [1:0]    arb_req, arb_grant;
  logic          grant_fire, gp;

  logic          owner_q, write_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] wdata_q, line_q, line_next;
  logic [BW-1:0] beat_q;
  logic [CW-1:0] wait_q;

  logic [1:0]    rsp_valid_q;
  logic          rsp_err_q;
  logic [LW-1:0] rdata_q;

  logic          rsp_seen, timeout_hit, last_beat;

  // ---------------------------------------------------------------- grant
  // Grants only in IDLE, and not in the cycle that carries the previous
  // completion pulse, so a new owner is chosen one cycle after rsp_valid.
  assign arb_req    = (state_q == IDLE && rsp_valid_q == 2'b00 && !reset)
                      ? req_valid : 2'b00;
  assign grant_fire = |arb_grant;
  assign gp         = arb_grant[1];
  assign req_ready  = arb_grant;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (grant_fire),
    .grant   (arb_grant)
  );

  // ------------------------------------------------------------- decoding
  assign rsp_seen    = (state_q == WAIT_RSP) && (mem_cmd == C2_RESPONSE);
  // A response sampled on the timeout cycle still wins.
  assign timeout_hit = (state_q == WAIT_RSP) && !rsp_seen &&
                       (wait_q == CW'(TIMEOUT_CYCLES - 1));
  assign last_beat   = (beat_q == BW'(BEATS - 1));

  // Read line with the beat currently on the bus merged in; becomes
  // rsp_rdata only once the final beat is in, so rsp_rdata never shows a
  // partially received line.
  always_comb begin
    line_next = line_q;
    line_next[beat_q*DW +: DW] = mem_data;
  end

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (grant_fire) state_d = req_write[gp] ? WR_BURST : RD_CMD;
      RD_CMD:   state_d = WAIT_RSP;
      WR_BURST: if (last_beat) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_seen)         state_d = (write_q || BEATS == 1) ? IDLE : RD_BURST;
        else if (timeout_hit) state_d = IDLE;
      end
      RD_BURST: if (last_beat) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------ bus outputs
  always_comb begin
    own_bus = 1'b0;
    cmd_o   = C2_NOP;
    data_o  = '0;
    unique case (state_q)
      IDLE:     own_bus = 1'b1;
      RD_CMD: begin
        own_bus = 1'b1;
        cmd_o   = C2_READ_LINE;
      end
      WR_BURST: begin
        own_bus = 1'b1;
        cmd_o   = C2_WRITE_LINE;
        data_o  = wdata_q[beat_q*DW +: DW];  // LSB beat first
      end
      default: ;  // WAIT_RSP / RD_BURST: memory owns the bus
    endcase
  end

  assign mem_cmd  = own_bus ? cmd_o  : 2'bzz;
  assign mem_data = own_bus ? data_o : {DW{1'bz}};
  assign mem_addr = addr_q;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (grant_fire) begin
            owner_q <= gp;
            write_q <= req_write[gp];
            addr_q  <= req_addr[gp];
            wdata_q <= req_wdata[gp];
            beat_q  <= '0;
          end
        end
        WR_BURST: beat_q <= last_beat ? '0 : beat_q + BW'(1);
        WAIT_RSP: begin
          wait_q <= wait_q + CW'(1);
          if (rsp_seen) begin
            wait_q <= '0;
            if (write_q) begin
              rsp_valid_q <= port_onehot(owner_q);
            end else begin
              line_q <= line_next;
              beat_q <= BW'(1);
              if (BEATS == 1) begin
                rdata_q     <= line_next;
                rsp_valid_q <= port_onehot(owner_q);
              end
            end
          end else if (timeout_hit) begin
            wait_q      <= '0;
            rsp_valid_q <= port_onehot(owner_q);
            rsp_err_q   <= 1'b1;
          end
        end
        RD_BURST: begin
          line_q <= line_next;
          beat_q <= last_beat ? '0 : beat_q + BW'(1);
          if (last_beat) begin
            rdata_q     <= line_next;
            rsp_valid_q <= port_onehot(owner_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus2_arbiter.sv
// Bench for mem_bus2_arbiter: behavioural bus-2 memory, two requesters and
// a scoreboard of expected completions (port, error, data, cycle).
module tb_mem_bus2_arbiter;
  import mem_bus2_arbiter_pkg::*;

  localparam int LW     = cache_line_size * BITS_IN_BYTE;
  localparam int AW     = addr2_bus_size * BITS_IN_BYTE;
  localparam int DW     = data2_bus_size * BITS_IN_BYTE;
  localparam int BEATS  = cache_line_size / data2_bus_size;
  localparam int TMO    = 16;
  localparam int F      = mem_feedback_time;
  localparam int RD_LAT = 1 + F + BEATS;
  localparam int WR_LAT = BEATS + F + 1;

  logic                clk, reset;
  logic [1:0]          req_valid, req_write, req_ready, rsp_valid;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][LW-1:0]  req_wdata;
  logic                rsp_err;
  logic [LW-1:0]       rsp_rdata;
  logic [AW-1:0]       mem_addr;
  wire  [DW-1:0]       mem_data;
  wire  [1:0]          mem_cmd;

  // memory-side bus drivers
  logic                mem_drv;
  logic [1:0]          mem_cmd_d;
  logic [DW-1:0]       mem_data_d;
  logic                mem_silent;
  assign mem_cmd  = mem_drv ? mem_cmd_d  : 2'bzz;
  assign mem_data = mem_drv ? mem_data_d : {DW{1'bz}};

  mem_bus2_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_cmd   (mem_cmd)
  );

  typedef struct {
    logic          port;
    logic          wr;
    logic          err;
    logic [LW-1:0] rdata;
    int            cyc;
  } sb_t;

  sb_t           sb[$];
  int            grant_order[$];
  logic [LW-1:0] mem_store [logic [AW-1:0]];
  logic [LW-1:0] ref_mem   [logic [AW-1:0]];
  logic [LW-1:0] last_good;
  logic [1:0]    grant_seen;
  int            grant_cyc[2];
  int            last_rsp_cyc;
  int            cyc;
  int            total, bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] mem_default(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*DW +: DW] = DW'(a) ^ DW'(k * 32'h1111_1111);
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*DW +: DW] = DW'($urandom());
    return l;
  endfunction

  function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  function automatic logic [LW-1:0] mem_read(input logic [AW-1:0] a);
    return mem_store.exists(a) ? mem_store[a] : mem_default(a);
  endfunction

  // ------------------------------------------------------- memory model
  task automatic respond(input logic wr, input logic [AW-1:0] a);
    logic [LW-1:0] line;
    int nb;
    line = wr ? '0 : mem_read(a);
    nb   = wr ? 1 : BEATS;
    repeat (F) @(posedge clk);
    #1;
    for (int k = 0; k < nb; k++) begin
      if (reset) break;
      mem_drv    = 1'b1;
      mem_cmd_d  = (k == 0) ? C2_RESPONSE : C2_NOP;
      mem_data_d = line[k*DW +: DW];
      @(posedge clk);
      #1;
    end
    mem_drv = 1'b0;
  endtask

  task automatic memory_model();
    int            wbeats;
    logic [AW-1:0] waddr;
    logic [LW-1:0] wline;
    wbeats = 0;
    forever begin
      @(negedge clk);
      if (reset || mem_silent) begin
        wbeats = 0;
        continue;
      end
      if (mem_cmd == C2_WRITE_LINE) begin
        if (wbeats == 0) waddr = mem_addr;
        wline[wbeats*DW +: DW] = mem_data;
        wbeats++;
        if (wbeats == BEATS) begin
          mem_store[waddr] = wline;
          wbeats = 0;
          respond(1'b1, waddr);
        end
      end else begin
        wbeats = 0;
        if (mem_cmd == C2_READ_LINE) respond(1'b0, mem_addr);
      end
    end
  endtask

  // ------------------------------------------------ monitor / scoreboard
  task automatic monitor();
    sb_t  e;
    logic p;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        last_good = '0;
        continue;
      end
      if (mem_drv) begin
        check("bus_cmd_contention", mem_cmd, mem_cmd_d);
        check("bus_data_contention", mem_data, mem_data_d);
      end
      if (rsp_valid != 2'b00) begin
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 2'b00);
        end else begin
          e = sb.pop_front();
          check("rsp_port", rsp_valid, 2'b01 << e.port);
          check("rsp_err", rsp_err, e.err);
          check("rsp_cycle", cyc, e.cyc);
          if (!e.wr && !e.err) last_good = e.rdata;
          check("rsp_rdata", rsp_rdata, last_good);
          check("reclaim_nop", mem_cmd, C2_NOP);
        end
      end else if (sb.size() == 0) begin
        check("idle_nop", mem_cmd, C2_NOP);
      end
      if (req_ready != 2'b00) begin
        check("ready_onehot", $onehot(req_ready), 1);
        p       = req_ready[1];
        e.port  = p;
        e.wr    = req_write[p];
        e.err   = mem_silent;
        e.rdata = ref_read(req_addr[p]);
        if (mem_silent) e.cyc = cyc + (req_write[p] ? BEATS + 1 : 2) + TMO;
        else            e.cyc = cyc + (req_write[p] ? WR_LAT : RD_LAT);
        if (req_write[p] && !mem_silent) ref_mem[req_addr[p]] = req_wdata[p];
        sb.push_back(e);
        grant_seen[p] = 1'b1;
        grant_cyc[p]  = cyc;
        grant_order.push_back(int'(p));
      end
    end
  endtask

  // -------------------------------------------------------- requesters
  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] d);
    req_write[p]  = wr;
    req_addr[p]   = a;
    req_wdata[p]  = d;
    grant_seen[p] = 1'b0;
    req_valid[p]  = 1'b1;
  endtask

  // Returns just after the edge that took the grant, with valid dropped.
  task automatic wait_grant(input int p);
    int n = 0;
    while (!grant_seen[p] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("grant_port%0d_seen", p), grant_seen[p], 1'b1);
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd"}, mem_cmd, C2_NOP);
    check({tag, "_addr"}, mem_addr, '0);
    check({tag, "_data"}, mem_data, '0);
    check({tag, "_ready"}, req_ready, 2'b00);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_rdata"}, rsp_rdata, '0);
  endtask

  // ------------------------------------------------------------- main
  logic [LW-1:0] line_a, line_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0; total = 0; bad = 0; last_rsp_cyc = 0;
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_drv = 1'b0; mem_cmd_d = C2_NOP; mem_data_d = '0; mem_silent = 1'b0;
    grant_seen = '0; last_good = '0;
    fork
      memory_model();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state, with both requests already pending
    set_req(0, 1'b0, AW'(20), '0);
    set_req(1, 1'b0, AW'(21), '0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // contention: port 0 first, port 1 one cycle after port 0 completes
    wait_grant(0);
    wait_grant(1);
    check("hold_grant_after_rsp", grant_cyc[1], last_rsp_cyc + 1);
    wait_done();
    set_req(0, 1'b1, AW'(30), rand_line());
    set_req(1, 1'b1, AW'(31), rand_line());
    wait_grant(0);
    wait_grant(1);
    wait_done();
    check("order_len", grant_order.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("order_%0d", i), grant_order[i], i % 2);

    // write then read back address 5, plus a cross-port pair
    line_a = rand_line();
    set_req(0, 1'b1, AW'(5), line_a);
    wait_grant(0);
    wait_done();
    set_req(0, 1'b0, AW'(5), '0);
    wait_grant(0);
    wait_done();
    check("readback_5", rsp_rdata, line_a);
    line_b = rand_line();
    set_req(1, 1'b1, AW'(9), line_b);
    wait_grant(1);
    wait_done();
    set_req(0, 1'b0, AW'(9), '0);
    wait_grant(0);
    wait_done();
    set_req(0, 1'b0, AW'(31), '0);
    wait_grant(0);
    wait_done();

    // port 0 raises a request while port 1 is mid-read
    set_req(1, 1'b0, AW'(0), '0);
    wait_grant(1);
    repeat (5) @(posedge clk);
    #1;
    set_req(0, 1'b0, AW'(5), '0);
    wait_grant(0);
    check("grant_cycle_after_rsp", grant_cyc[0], last_rsp_cyc + 1);
    wait_done();

    // silent memory: read and write both time out
    mem_silent = 1'b1;
    set_req(0, 1'b0, AW'(7), '0);
    wait_grant(0);
    wait_done();
    set_req(1, 1'b1, AW'(8), rand_line());
    wait_grant(1);
    wait_done();
    mem_silent = 1'b0;

    // reset during write beat 3, then a normal read
    set_req(0, 1'b1, AW'(12), rand_line());
    wait_grant(0);
    repeat (3) @(posedge clk);
    #2;
    set_req(1, 1'b0, AW'(5), '0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    reset = 1'b0;
    wait_grant(1);
    wait_done();
    check("post_reset_read", rsp_rdata, line_a);
    line_b = rand_line();
    set_req(0, 1'b1, AW'(12), line_b);
    wait_grant(0);
    wait_done();
    set_req(1, 1'b0, AW'(12), '0);
    wait_grant(1);
    wait_done();
    check("post_reset_readback", rsp_rdata, line_b);

    repeat (3) @(posedge clk);
    check("sb_final_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus2_arbiter.md
MEM_BUS2_ARBITER -- requirements
Module: mem_bus2_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: max cycles waiting for C2_RESPONSE after bus release.
REQ-002 SHALL derive localparam BEATS = cache_line_size / data2_bus_size, the bus-2 beats per line.
REQ-003 SHALL define LW = cache_line_size*BITS_IN_BYTE, AW = addr2_bus_size*BITS_IN_BYTE, DW = data2_bus_size*BITS_IN_BYTE.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  [1:0]  per-requester line-transfer request.
REQ-007 req_ready  output  [1:0]  request accepted this cycle; at most one bit high.
REQ-008 req_write  input  [1:0]  1 = write line, 0 = read line.
REQ-009 req_addr  input  [1:0][AW-1:0]  line address per requester.
REQ-010 req_wdata  input  [1:0][LW-1:0]  write line per requester.
REQ-011 rsp_valid  output  [1:0]  one-cycle completion pulse to the owning requester.
REQ-012 rsp_err  output  1  qualifies rsp_valid; 1 = timeout.
REQ-013 rsp_rdata  output  LW  read line; held until the next read completes.
REQ-014 mem_addr  output  AW  bus-2 address.
REQ-015 mem_data  inout  DW  bus-2 data; driven only while the master owns the bus, else high-Z.
REQ-016 mem_cmd  inout  2  bus-2 command; driven only while the master owns the bus, else 2'bzz.

Function
REQ-017 SHALL implement states IDLE, RD_CMD, WR_BURST, WAIT_RSP, RD_BURST.
REQ-018 In IDLE: drive C2_NOP, own the bus, grant one valid requester by round-robin, and assert its req_ready combinationally.
REQ-019 Round-robin: the last-granted port gets lowest priority; after reset port 0 has priority; a single valid port is always granted.
REQ-020 On grant: latch port id, addr, write and wdata; go to WR_BURST if write, else RD_CMD.
REQ-021 RD_CMD (1 cycle): drive C2_READ_LINE and mem_addr; next state WAIT_RSP with the bus released.
REQ-022 WR_BURST (BEATS cycles): drive C2_WRITE_LINE, mem_addr, and beat k = wdata[k*DW +: DW] in cycle k, LSB beat first; then WAIT_RSP, released.
REQ-023 WAIT_RSP: count cycles; on sampling mem_cmd==C2_RESPONSE, a write goes to IDLE and pulses rsp_valid, and a read captures beat 0 and goes to RD_BURST.
REQ-024 RD_BURST: capture beats 1..BEATS-1 on the following BEATS-1 posedges into rsp_rdata[k*DW +: DW]; then reclaim the bus, pulse rsp_valid, and go to IDLE.
REQ-025 Write latency, grant to rsp_valid, SHALL be BEATS + mem_feedback_time cycles (+1 registration); read SHALL be 1 + mem_feedback_time + BEATS.
REQ-026 If the WAIT_RSP count reaches TIMEOUT_CYCLES: pulse rsp_valid with rsp_err=1, leave rsp_rdata unchanged, reclaim the bus, and go to IDLE.
REQ-027 No new grant SHALL occur until the cycle after rsp_valid (IDLE re-entry); requests held meanwhile SHALL stay pending.
REQ-028 mem_cmd/mem_data SHALL never be driven in WAIT_RSP or RD_BURST (no bus contention).
REQ-029 A requester deasserting req_valid before grant SHALL be legal; after req_ready the transfer completes regardless.

Reset
REQ-030 On reset (any state, any cycle): state=IDLE, bus owned, mem_cmd=C2_NOP, mem_addr=0, mem_data=0, req_ready=0 during reset, rsp_valid=0, rsp_err=0, rsp_rdata=0, RR priority=port 0, counters=0.
REQ-031 Reset mid-transfer SHALL drop the transfer with no rsp_valid.

Structure
REQ-032 C2_* command encodings, BITS_IN_BYTE, cache_line_size, data2_bus_size, addr2_bus_size and mem_feedback_time SHALL come from the shared package; the state enum goes in the package.
REQ-033 The round-robin grant SHALL be a sub-module rr_arbiter2 (req[1:0], advance, grant[1:0]); the rest is one module.

Verification
REQ-034 Port 0 writes addr 5 with a random line, then reads addr 5 -> rsp_rdata equals the line, rsp_err=0, latencies per REQ-025.
REQ-035 Both ports valid in the same cycle after reset -> port 0 served first, then port 1; repeated contention alternates 0,1,0,1.
REQ-036 Port 1 reads addr 0 while port 0 raises a request mid-read -> port 0 granted exactly the cycle after port 1's rsp_valid.
REQ-037 Memory never responds (TIMEOUT_CYCLES=16) -> rsp_valid with rsp_err=1 at cycle 16 of WAIT_RSP; bus reclaimed with NOP.
REQ-038 Reset asserted in WR_BURST beat 3 -> outputs at reset values immediately, no rsp_valid; next request completes normally.
REQ-039 Continuous check: mem_cmd never X and never driven by both sides; exactly one rsp_valid per accepted request.
